mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

Controller between the MEM stage and the external 16-bit asynchronous SRAM. It takes the memory request held in the EX/MEM pipeline register (read enable, write enable, ALU address, store value) and runs each 32-bit access as two 16-bit SRAM phases with programmable wait states. While an access is in progress it drives `ready` low, which freezes the pipeline. It returns the assembled 32-bit read word to write-back.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles each half-word phase is held (phase length = WAIT_CYCLES+1; legal range 0..15).
- `ADDR_OFFSET`, default 1024: byte address subtracted from `address` before mapping into SRAM.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_r_en` in 1: load request from the EX/MEM register.
- `mem_w_en` in 1: store request from the EX/MEM register.
- `address` in 32: byte address (ALU result).
- `st_val` in 32: store data.
- `ready` out 1: 1 = no access pending or access completing this cycle; 0 = freeze the pipeline.
- `rd_data` out 32: last completed read word.
- `sram_addr` out 18: half-word address.
- `sram_dq_out` out 16: write data to the SRAM.
- `sram_dq_oe` out 1: 1 = controller drives the data bus.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_we_n` out 1: active-low write strobe.
- `sram_oe_n` out 1: active-low output enable.

## Operation
- Request `req` = `mem_r_en` | `mem_w_en`. If both are 1, the access is a write.
- States and transitions:
  - IDLE: if `req`, latch `addr_q` = `address` − `ADDR_OFFSET`, `data_q` = `st_val`, `wr_q` = write flag, then go to LOW.
  - LOW: low half-word phase, held WAIT_CYCLES+1 cycles via a 4-bit counter, then go to HIGH.
  - HIGH: high half-word phase, same length, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- Address mapping: `sram_addr` = {`addr_q`[18:2], 0} in LOW and {`addr_q`[18:2], 1} in HIGH. Address bits [1:0] and [31:19] are ignored. Addresses below `ADDR_OFFSET` wrap modulo 2^32 with no error.
- Write phases:
  - `sram_we_n` = 0 and `sram_dq_oe` = 1 for every cycle of the phase.
  - `sram_dq_out` = `data_q`[15:0] in LOW and `data_q`[31:16] in HIGH.
- Read phases:
  - `sram_oe_n` = 0.
  - `sram_dq_in` is sampled into `rd_data`[15:0] on the edge that ends LOW, and into `rd_data`[31:16] on the edge that ends HIGH.
  - `rd_data` keeps its value through writes and idle periods.
- Outside active phases: `sram_we_n` = `sram_oe_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
- `ready` = (IDLE and not `req`) or DONE. This is combinational, so a new request sampled in IDLE drops `ready` in the same cycle.
- Request inputs are ignored in LOW, HIGH and DONE. The frozen pipeline holds them stable.

## Timing
- Reset (asynchronous, `rst` = 0):
  - state = IDLE, counter = 0, `addr_q`/`data_q`/`wr_q` = 0, `rd_data` = 0.
  - Resulting outputs: `ready` = 1 if no request, `sram_we_n` = `sram_oe_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
- Access length: cycle 1 (request seen in IDLE) + 2·(WAIT_CYCLES+1) phase cycles + 1 DONE cycle. `ready` is 0 for 2·WAIT_CYCLES+3 cycles and 1 in the DONE cycle.
  - WAIT_CYCLES=1: `ready` is low in cycles 1–5 and high in cycle 6.
  - WAIT_CYCLES=0: `ready` is low in cycles 1–3 and high in cycle 4.
- `rd_data` is valid in the DONE cycle, which is when the pipeline register captures it.
- Back-to-back: the pipeline advances at the end of DONE. The next request is seen in IDLE the following cycle, giving one idle-state cycle between accesses.
- Reset asserted mid-access aborts immediately. Outputs go inactive at once. A partially written SRAM word is acceptable. A partially updated `rd_data` is cleared to 0.

## Test plan
- Reset then idle: `rst` low then high with `mem_r_en` = `mem_w_en` = 0 → all outputs at reset values and `ready` = 1 for 10 cycles.
- Read, WAIT_CYCLES=1: `address` = 1032, SRAM model returns 0x5678 at half-word 4 and 0x1234 at half-word 5 → `sram_addr` is 4 for 2 cycles then 5 for 2 cycles, `sram_oe_n` = 0 throughout, `ready` goes high in cycle 6, `rd_data` = 0x12345678.
- Write: `address` = 1036, `st_val` = 0xDEADBEEF → half-word 6 gets 0xBEEF and half-word 7 gets 0xDEAD, `sram_we_n` = 0 for 4 cycles, `rd_data` unchanged.
- Simultaneous `mem_r_en` = `mem_w_en` = 1 → write performed, `sram_oe_n` stays 1.
- Back-to-back read at 1040 then write at 1040 with 0xCAFEF00D, WAIT_CYCLES=0 → `ready` pattern 0,0,0,1,0,0,0,1, and a following read returns 0xCAFEF00D.
- `rst` pulsed low during HIGH of a read → state IDLE at once, `rd_data` = 0, `sram_oe_n` = 1 in the same cycle, and the next request completes normally.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//   Bridges the MEM pipeline stage to an external 16-bit asynchronous SRAM.
//   Each 32-bit load/store runs as two half-word phases (low, then high).
//   Each phase lasts WAIT_CYCLES+1 clocks. The pipeline is frozen via
//   `ready` while an access is in flight.
//
// Parameters
//   WAIT_CYCLES  extra cycles per half-word phase (0..15)
//   ADDR_OFFSET  byte address subtracted from `address` before SRAM mapping
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active low
//   mem_r_en     load request from EX/MEM
//   mem_w_en     store request from EX/MEM (wins when both are set)
//   address      byte address
//   st_val       store data
//   ready        1 = idle with no request, or access completing this cycle
//   rd_data      last completed read word
//   sram_addr    half-word address to the SRAM
//   sram_dq_out  write data to the SRAM
//   sram_dq_oe   1 = controller drives the data bus
//   sram_dq_in   read data from the SRAM
//   sram_we_n    active-low write strobe
//   sram_oe_n    active-low output enable
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; a request latches address/data and starts LOW
// LOW   | low half-word phase, WAIT_CYCLES+1 cycles
// HIGH  | high half-word phase, WAIT_CYCLES+1 cycles
// DONE  | one cycle with ready=1; rd_data valid for write-back

module mem_stage_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_OFFSET = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] st_val,
    output logic        ready,
    output logic [31:0] rd_data,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] PHASE_LOAD = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        wr_q;

    logic        req;
    logic        wr_req;
    logic [31:0] addr_map;
    logic        addr_unused;

    assign req      = mem_r_en | mem_w_en;
    assign wr_req   = mem_w_en;
    // Addresses below the offset simply wrap modulo 2^32.
    assign addr_map = address - ADDR_OFFSET;

    // Byte-lane bits and the bits above the 512 KiB window are ignored.
    assign addr_unused = ^{addr_q[31:19], addr_q[1:0]};

    // Combinational so a request seen in IDLE freezes the pipeline at once.
    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // Phase timing uses a down-counter loaded with WAIT_CYCLES on phase
    // entry. The phase ends on the edge where the counter is already zero.
    // SRAM pins are registered. They are loaded for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            wr_q        <= 1'b0;
            rd_data     <= 32'd0;
            sram_addr   <= 18'd0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LOW;
                        addr_q      <= addr_map;
                        data_q      <= st_val;
                        wr_q        <= wr_req;
                        cnt         <= PHASE_LOAD;
                        sram_addr   <= {addr_map[18:2], 1'b0};
                        sram_we_n   <= ~wr_req;
                        sram_oe_n   <= wr_req;
                        sram_dq_oe  <= wr_req;
                        sram_dq_out <= wr_req ? st_val[15:0] : 16'd0;
                    end
                end
                LOW: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state       <= HIGH;
                        cnt         <= PHASE_LOAD;
                        sram_addr   <= {addr_q[18:2], 1'b1};
                        sram_dq_out <= wr_q ? data_q[31:16] : 16'd0;
                        if (!wr_q) begin
                            rd_data[15:0] <= sram_dq_in;
                        end
                    end
                end
                HIGH: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state       <= DONE;
                        cnt         <= 4'd0;
                        sram_addr   <= 18'd0;
                        sram_dq_out <= 16'd0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        if (!wr_q) begin
                            rd_data[31:16] <= sram_dq_in;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl
//   Two controller instances share clk/rst/address/st_val but have separate
//   request lines and SRAM models. Index 0 uses WAIT_CYCLES=1; index 1 uses
//   WAIT_CYCLES=0. Expected read words come from a bench-side memory model.
//   They are queued when a request is driven and compared in the DONE cycle.

module tb_mem_stage_sram_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        r_en;
    logic [1:0]        w_en;
    logic [31:0]       address;
    logic [31:0]       st_val;

    logic [1:0]        ready_v;
    logic [1:0][31:0]  rd_data_v;
    logic [1:0][17:0]  sram_addr_v;
    logic [1:0][15:0]  dq_out_v;
    logic [1:0][15:0]  dq_in_v;
    logic [1:0]        dq_oe_v;
    logic [1:0]        we_n_v;
    logic [1:0]        oe_n_v;

    logic [15:0]       sram_mem [2][256];
    logic [15:0]       model    [2][256];
    logic [31:0]       last_rd  [2];
    logic [31:0]       exp_q    [$];

    logic              pre_we;
    int                pre_sel;
    logic [7:0]        pre_idx;
    logic [15:0]       pre_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .ADDR_OFFSET(32'd1024)) u_dut_w1 (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (r_en[0]),
        .mem_w_en    (w_en[0]),
        .address     (address),
        .st_val      (st_val),
        .ready       (ready_v[0]),
        .rd_data     (rd_data_v[0]),
        .sram_addr   (sram_addr_v[0]),
        .sram_dq_out (dq_out_v[0]),
        .sram_dq_oe  (dq_oe_v[0]),
        .sram_dq_in  (dq_in_v[0]),
        .sram_we_n   (we_n_v[0]),
        .sram_oe_n   (oe_n_v[0])
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(0), .ADDR_OFFSET(32'd1024)) u_dut_w0 (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (r_en[1]),
        .mem_w_en    (w_en[1]),
        .address     (address),
        .st_val      (st_val),
        .ready       (ready_v[1]),
        .rd_data     (rd_data_v[1]),
        .sram_addr   (sram_addr_v[1]),
        .sram_dq_out (dq_out_v[1]),
        .sram_dq_oe  (dq_oe_v[1]),
        .sram_dq_in  (dq_in_v[1]),
        .sram_we_n   (we_n_v[1]),
        .sram_oe_n   (oe_n_v[1])
    );

    // SRAM models: 256 half-words, indexed by the low address bits.
    assign dq_in_v[0] = oe_n_v[0] ? 16'hFFFF : sram_mem[0][sram_addr_v[0][7:0]];
    assign dq_in_v[1] = oe_n_v[1] ? 16'hFFFF : sram_mem[1][sram_addr_v[1][7:0]];

    always @(posedge clk) begin
        if (pre_we) begin
            sram_mem[pre_sel][pre_idx] <= pre_data;
        end
        for (int g = 0; g < 2; g++) begin
            if (!we_n_v[g] && dq_oe_v[g]) begin
                sram_mem[g][sram_addr_v[g][7:0]] <= dq_out_v[g];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic preload(input int sel, input logic [7:0] idx, input logic [15:0] v);
        pre_sel  = sel;
        pre_idx  = idx;
        pre_data = v;
        pre_we   = 1'b1;
        model[sel][idx] = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        r_en = 2'b00;
        w_en = 2'b00;
    endtask

    // Drives one request and checks every cycle until the DONE cycle.
    task automatic access(input int sel, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic [17:0] hw;
        logic [7:0]  i0;
        logic [7:0]  i1;
        logic [31:0] exp_rd;
        int          ph;
        int          total;
        off   = a - 32'd1024;
        hw    = {off[18:2], 1'b0};
        i0    = hw[7:0];
        i1    = i0 + 8'd1;
        ph    = (sel == 0) ? 2 : 1;
        total = 2 * ph + 2;
        if (w) begin
            model[sel][i0] = d[15:0];
            model[sel][i1] = d[31:16];
            exp_rd = last_rd[sel];
        end else begin
            exp_rd = {model[sel][i1], model[sel][i0]};
            last_rd[sel] = exp_rd;
        end
        exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        address   = a;
        st_val    = d;
        r_en[sel] = r;
        w_en[sel] = w;
        for (int n = 1; n <= total; n++) begin
            bit          act;
            bit          hi;
            logic [17:0] ea;
            logic [15:0] eo;
            @(negedge clk);
            act = (n >= 2) && (n <= total - 1);
            hi  = (n >= 2 + ph);
            ea  = act ? (hw | 18'(hi)) : 18'd0;
            eo  = (act && w) ? (hi ? d[31:16] : d[15:0]) : 16'd0;
            check_val("ready", 32'(ready_v[sel]), 32'(n == total));
            check_val("sram_addr", 32'(sram_addr_v[sel]), 32'(ea));
            check_val("sram_we_n", 32'(we_n_v[sel]), 32'(!(act && w)));
            check_val("sram_oe_n", 32'(oe_n_v[sel]), 32'(!(act && !w)));
            check_val("sram_dq_oe", 32'(dq_oe_v[sel]), 32'(act && w));
            check_val("sram_dq_out", 32'(dq_out_v[sel]), 32'(eo));
            if (n == total) begin
                check_val("rd_data", rd_data_v[sel], exp_q.pop_front());
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        r_en     = 2'b00;
        w_en     = 2'b00;
        address  = 32'd0;
        st_val   = 32'd0;
        pre_we   = 1'b0;
        pre_sel  = 0;
        pre_idx  = 8'd0;
        pre_data = 16'd0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;

        preload(0, 8'd4, 16'h5678);
        preload(0, 8'd5, 16'h1234);
        preload(1, 8'd8, 16'h3C3C);
        preload(1, 8'd9, 16'h5A5A);

        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_val("rst_rd_data", rd_data_v[s], 32'd0);
            check_val("rst_sram_addr", 32'(sram_addr_v[s]), 32'd0);
            check_val("rst_dq_out", 32'(dq_out_v[s]), 32'd0);
            check_val("rst_dq_oe", 32'(dq_oe_v[s]), 32'd0);
            check_val("rst_we_n", 32'(we_n_v[s]), 32'd1);
            check_val("rst_oe_n", 32'(oe_n_v[s]), 32'd1);
        end

        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val("idle_ready0", 32'(ready_v[0]), 32'd1);
            check_val("idle_ready1", 32'(ready_v[1]), 32'd1);
            check_val("idle_addr", 32'(sram_addr_v[0]), 32'd0);
            check_val("idle_we_n", 32'(we_n_v[0]), 32'd1);
            check_val("idle_oe_n", 32'(oe_n_v[0]), 32'd1);
        end

        // WAIT_CYCLES=1: read, write, simultaneous r/w, read-back
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle();
        access(0, 1'b0, 1'b1, 32'd1036, 32'hDEADBEEF);
        idle();
        check_val("sram_hw6", 32'(sram_mem[0][6]), 32'h0000BEEF);
        check_val("sram_hw7", 32'(sram_mem[0][7]), 32'h0000DEAD);
        access(0, 1'b1, 1'b1, 32'd1044, 32'h0BADF00D);
        idle();
        check_val("sram_hw10", 32'(sram_mem[0][10]), 32'h0000F00D);
        check_val("sram_hw11", 32'(sram_mem[0][11]), 32'h00000BAD);
        access(0, 1'b1, 1'b0, 32'd1036, 32'h0);
        idle();

        // WAIT_CYCLES=0: back-to-back read, write, read
        access(1, 1'b1, 1'b0, 32'd1040, 32'h0);
        access(1, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
        access(1, 1'b1, 1'b0, 32'd1040, 32'h0);
        idle();

        // Address below the offset wraps
        access(1, 1'b0, 1'b1, 32'd0, 32'h13579BDF);
        access(1, 1'b1, 1'b0, 32'd0, 32'h0);
        idle();

        // Reset pulsed in the first HIGH cycle of a read
        @(posedge clk);
        #1;
        address = 32'd1036;
        r_en[0] = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("abort_rd_data", rd_data_v[0], 32'd0);
        check_val("abort_oe_n", 32'(oe_n_v[0]), 32'd1);
        check_val("abort_addr", 32'(sram_addr_v[0]), 32'd0);
        check_val("abort_ready_req", 32'(ready_v[0]), 32'd0);
        r_en[0] = 1'b0;
        #1;
        check_val("abort_ready_idle", 32'(ready_v[0]), 32'd1);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(posedge clk);
        #1 rst = 1'b1;
        access(0, 1'b1, 1'b0, 32'd1032, 32'h0);
        idle();

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
